// File: rtl/instr_decode_if.sv
// instr_decode_if: fetch-side, execute-side and writeback signals of the decode stage.
interface instr_decode_if #(parameter int XLEN = 32);
    logic            en, in_valid, in_ready, rf_readEn, out_valid, out_ready;
    logic            rd_wen, illegal, wb_valid;
    logic [XLEN-1:0] instr, pc_in, imm, pc_out;
    logic [4:0]      rs1, rs2, rd, wb_rd;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    modport master (
        output en, in_valid, instr, pc_in, out_ready, wb_valid, wb_rd,
        input  in_ready, rs1, rs2, rf_readEn, out_valid, opcode, funct3, funct7,
               imm, rd, rd_wen, pc_out, illegal
    );
    modport slave (
        input  en, in_valid, instr, pc_in, out_ready, wb_valid, wb_rd,
        output in_ready, rs1, rs2, rf_readEn, out_valid, opcode, funct3, funct7,
               imm, rd, rd_wen, pc_out, illegal
    );
endinterface

// File: rtl/instr_decode.sv
// instr_decode: RV32I decode stage; DECODE_SCOREBOARD_EN adds a busy-register scoreboard.
module instr_decode (
    input logic           clk,
    input logic           reset,
    instr_decode_if.slave bus
);
    localparam int XLEN = $bits(bus.instr);
    typedef enum logic [1:0] {EMPTY, FULL, HALT} state_t;
    state_t state;
    logic [XLEN-1:0] ins, imm_d;
    logic lui, auipc, jal, jalr, branch, load, store, opimm, op_r;
    logic legal, use1, use2, wen, hazard, accept;
    assign ins = bus.instr;
    always_comb begin
        lui    = ins[6:0] == 7'b0110111;
        auipc  = ins[6:0] == 7'b0010111;
        jal    = ins[6:0] == 7'b1101111;
        jalr   = ins[6:0] == 7'b1100111;
        branch = ins[6:0] == 7'b1100011;
        load   = ins[6:0] == 7'b0000011;
        store  = ins[6:0] == 7'b0100011;
        opimm  = ins[6:0] == 7'b0010011;
        op_r   = ins[6:0] == 7'b0110011;
        legal  = lui | auipc | jal | jalr | branch | load | store | opimm | op_r;
        use1   = jalr | branch | load | store | opimm | op_r;
        use2   = branch | store | op_r;
        wen    = (lui | auipc | jal | jalr | load | opimm | op_r) && ins[11:7] != 5'd0;
        // Unsupported opcodes fall through every format and yield a zero immediate.
        imm_d  = (load | opimm | jalr) ? {{(XLEN-11){ins[31]}}, ins[30:20]} :
                 store  ? {{(XLEN-11){ins[31]}}, ins[30:25], ins[11:7]} :
                 branch ? {{(XLEN-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0} :
                 (lui | auipc) ? {{(XLEN-31){ins[31]}}, ins[30:12], 12'b0} :
                 jal    ? {{(XLEN-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0} :
                 '0;
    end
`ifdef DECODE_SCOREBOARD_EN
    logic [31:1] busy;
    logic [31:0] bz;
    assign bz     = {busy, 1'b0};
    assign hazard = (use1 && bz[ins[19:15]]) || (use2 && bz[ins[24:20]]) || (wen && bz[ins[11:7]]);
`else
    assign hazard = 1'b0;
`endif
    assign bus.in_ready  = reset && bus.en && state != HALT && (!bus.out_valid || bus.out_ready) &&
                           !bus.wb_valid && !hazard;
    assign accept        = bus.in_ready && bus.in_valid;
    assign bus.rf_readEn = accept;
    assign bus.rs1       = ins[19:15];
    assign bus.rs2       = ins[24:20];
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= EMPTY;
            bus.out_valid <= 1'b0;
            bus.opcode    <= '0;
            bus.funct3    <= '0;
            bus.funct7    <= '0;
            bus.imm       <= '0;
            bus.rd        <= '0;
            bus.rd_wen    <= 1'b0;
            bus.pc_out    <= '0;
            bus.illegal   <= 1'b0;
`ifdef DECODE_SCOREBOARD_EN
            busy          <= '0;
`endif
        end else begin
            if (accept) begin
                state         <= legal ? FULL : HALT;
                bus.out_valid <= 1'b1;
                bus.opcode    <= ins[6:0];
                bus.funct3    <= ins[14:12];
                bus.funct7    <= ins[31:25];
                bus.imm       <= imm_d;
                bus.rd        <= ins[11:7];
                bus.rd_wen    <= wen;
                bus.pc_out    <= bus.pc_in;
                bus.illegal   <= !legal;
            end else if (bus.en && bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
                if (state == FULL) state <= EMPTY;
            end
`ifdef DECODE_SCOREBOARD_EN
            // Writeback clears are honoured even while the stage is disabled; a same-cycle set wins.
            for (int k = 1; k < 32; k++)
                if (accept && wen && ins[11:7] == 5'(k)) busy[k] <= 1'b1;
                else if (bus.wb_valid && bus.wb_rd == 5'(k)) busy[k] <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: directed-vector bench for instr_decode; scoreboard expectations follow DECODE_SCOREBOARD_EN.
module tb_instr_decode;
    localparam logic [31:0] ADDI = 32'hFFF00293, SW = 32'h0020A423, LUI = 32'h123453B7;
    localparam logic [31:0] ADD = 32'h00528333, BAD = 32'hFFFFFFFF;
    logic clk = 1'b0, reset = 1'b0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    instr_decode_if bus ();
    instr_decode dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.en = 1'b1; bus.in_valid = 1'b0; bus.instr = '0; bus.pc_in = '0;
        bus.out_ready = 1'b1; bus.wb_valid = 1'b0; bus.wb_rd = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0; bus.in_valid = 1'b1; bus.instr = ADDI;
        tick(); tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %h want 0", bus.out_valid); end
        checks++; if (bus.opcode !== 7'h00) begin errors++; $display("FAIL reset_opcode got %h want 00", bus.opcode); end
        checks++; if (bus.imm !== 32'h0) begin errors++; $display("FAIL reset_imm got %h want 0", bus.imm); end
        checks++; if (bus.pc_out !== 32'h0 || bus.rd_wen !== 1'b0) begin errors++; $display("FAIL reset_pc_wen got %h/%h want 0/0", bus.pc_out, bus.rd_wen); end
        checks++; if (bus.in_ready !== 1'b0 || bus.rf_readEn !== 1'b0) begin errors++; $display("FAIL reset_ready got %h/%h want 0/0", bus.in_ready, bus.rf_readEn); end
    endtask

    task automatic test_addi();
        do_reset();
        bus.in_valid = 1'b1; bus.instr = ADDI; bus.pc_in = 32'h100;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.rf_readEn !== 1'b1) begin errors++; $display("FAIL addi_accept got %h/%h want 1/1", bus.in_ready, bus.rf_readEn); end
        checks++; if (bus.rs1 !== 5'd0) begin errors++; $display("FAIL addi_rs1 got %0d want 0", bus.rs1); end
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.opcode !== 7'h13) begin errors++; $display("FAIL addi_valid_op got %h/%h want 1/13", bus.out_valid, bus.opcode); end
        checks++; if (bus.rd !== 5'd5 || bus.rd_wen !== 1'b1) begin errors++; $display("FAIL addi_rd got %0d/%h want 5/1", bus.rd, bus.rd_wen); end
        checks++; if (bus.imm !== 32'hFFFFFFFF || bus.pc_out !== 32'h100) begin errors++; $display("FAIL addi_imm_pc got %h/%h want ffffffff/100", bus.imm, bus.pc_out); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got %h want 0", bus.out_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.instr = SW; bus.pc_in = 32'h200;
        #1;
        checks++; if (bus.rs1 !== 5'd1 || bus.rs2 !== 5'd2) begin errors++; $display("FAIL sw_rs got %0d/%0d want 1/2", bus.rs1, bus.rs2); end
        tick();
        bus.instr = ADDI; bus.pc_in = 32'h300;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0 || bus.rf_readEn !== 1'b0) begin errors++; $display("FAIL stall_ready c%0d got %h/%h want 0/0", c, bus.in_ready, bus.rf_readEn); end
            checks++; if (bus.out_valid !== 1'b1 || bus.imm !== 32'h8 || bus.rd_wen !== 1'b0) begin errors++; $display("FAIL stall_hold c%0d got v%h imm %h wen %h want 1/8/0", c, bus.out_valid, bus.imm, bus.rd_wen); end
            checks++; if (bus.pc_out !== 32'h200 || bus.funct3 !== 3'd2) begin errors++; $display("FAIL stall_pc c%0d got %h/%h want 200/2", c, bus.pc_out, bus.funct3); end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %h want 1", bus.in_ready); end
        tick();
        checks++; if (bus.pc_out !== 32'h300 || bus.imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL stall_next got %h/%h want 300/ffffffff", bus.pc_out, bus.imm); end
        bus.instr = LUI; bus.pc_in = 32'h304;
        tick();
        checks++; if (bus.opcode !== 7'h37 || bus.imm !== 32'h12345000 || bus.rd !== 5'd7 || bus.pc_out !== 32'h304) begin errors++; $display("FAIL back_to_back got op %h imm %h rd %0d pc %h want 37/12345000/7/304", bus.opcode, bus.imm, bus.rd, bus.pc_out); end
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %h want 0", bus.out_valid); end
    endtask

    task automatic test_wb();
        do_reset();
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.in_valid = 1'b1; bus.instr = ADDI; bus.pc_in = 32'h400;
        #1;
        checks++; if (bus.in_ready !== 1'b0 || bus.rf_readEn !== 1'b0) begin errors++; $display("FAIL wb_block got %h/%h want 0/0", bus.in_ready, bus.rf_readEn); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL wb_no_accept got %h want 0", bus.out_valid); end
        bus.wb_valid = 1'b0;
        #1;
        checks++; if (bus.rf_readEn !== 1'b1) begin errors++; $display("FAIL wb_release got %h want 1", bus.rf_readEn); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 32'h400) begin errors++; $display("FAIL wb_accept got %h/%h want 1/400", bus.out_valid, bus.pc_out); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_formats();
        logic [31:0] ins [5] = '{32'hFE208EE3, 32'h00008067, 32'h001000EF, 32'h80000197, 32'h40528333};
        logic [31:0] imm [5] = '{32'hFFFFFFFC, 32'h0, 32'h800, 32'h80000000, 32'h0};
        logic        wen [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [6:0]  opc [5] = '{7'h63, 7'h67, 7'h6F, 7'h17, 7'h33};
        logic [6:0]  f7  [5] = '{7'h7F, 7'h00, 7'h00, 7'h40, 7'h20};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1; bus.instr = ins[k]; bus.pc_in = 32'(k * 4);
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 32'(k * 4)) begin errors++; $display("FAIL fmt%0d_issue got %h/%h want 1/%h", k, bus.out_valid, bus.pc_out, k * 4); end
            checks++; if (bus.imm !== imm[k] || bus.rd_wen !== wen[k]) begin errors++; $display("FAIL fmt%0d_imm got %h/%h want %h/%h", k, bus.imm, bus.rd_wen, imm[k], wen[k]); end
            checks++; if (bus.opcode !== opc[k] || bus.funct7 !== f7[k] || bus.illegal !== 1'b0) begin errors++; $display("FAIL fmt%0d_fields got %h/%h/%h want %h/%h/0", k, bus.opcode, bus.funct7, bus.illegal, opc[k], f7[k]); end
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_enable();
        do_reset();
        bus.in_valid = 1'b1; bus.instr = ADDI; bus.pc_in = 32'h500;
        tick();
        bus.instr = LUI; bus.pc_in = 32'h504; bus.en = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL en_ready got %h want 0", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 32'h500) begin errors++; $display("FAIL en_hold got %h/%h want 1/500", bus.out_valid, bus.pc_out); end
        bus.en = 1'b1; bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL en_resume got %h want 0", bus.out_valid); end
    endtask

    task automatic test_scoreboard();
        do_reset();
        bus.in_valid = 1'b1; bus.instr = ADDI; bus.pc_in = 32'h600;
        tick();
        bus.instr = ADD; bus.pc_in = 32'h604;
`ifdef DECODE_SCOREBOARD_EN
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL sb_stall c%0d got %h want 0", c, bus.in_ready); end
            tick();
        end
        checks++; if (bus.pc_out !== 32'h600) begin errors++; $display("FAIL sb_hold got %h want 600", bus.pc_out); end
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd5;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL sb_wb_cycle got %h want 0", bus.in_ready); end
        tick();
        bus.wb_valid = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL sb_cleared got %h want 1", bus.in_ready); end
`else
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL nosb_ready got %h want 1", bus.in_ready); end
`endif
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 32'h604 || bus.opcode !== 7'h33) begin errors++; $display("FAIL sb_accept got %h/%h/%h want 1/604/33", bus.out_valid, bus.pc_out, bus.opcode); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        do_reset();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.instr = BAD; bus.pc_in = 32'h700;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ill_accept got %h want 1", bus.in_ready); end
        tick();
        checks++; if (bus.illegal !== 1'b1 || bus.rd_wen !== 1'b0 || bus.imm !== 32'h0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL ill_fields got ill %h wen %h imm %h v %h want 1/0/0/1", bus.illegal, bus.rd_wen, bus.imm, bus.out_valid); end
        bus.instr = ADDI; bus.pc_in = 32'h704;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ill_halt_full got %h want 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL ill_consumed got %h/%h want 0/0", bus.out_valid, bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.pc_out !== 32'h700) begin errors++; $display("FAIL ill_refuse got %h/%h want 0/700", bus.out_valid, bus.pc_out); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.illegal !== 1'b0) begin errors++; $display("FAIL ill_reset got %h/%h want 1/0", bus.in_ready, bus.illegal); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 32'h704 || bus.opcode !== 7'h13) begin errors++; $display("FAIL ill_resume got %h/%h/%h want 1/704/13", bus.out_valid, bus.pc_out, bus.opcode); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_stall();
        test_wb();
        test_formats();
        test_enable();
        test_scoreboard();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_decode.md
# instr_decode

Decode stage between instruction fetch and the 32×32 register file. It accepts one RV32I instruction per handshake, drives the register-file read addresses and read enable in the same cycle, and registers the decoded fields (opcode, funct, immediate, rd) for execute. Register-file read data arrives on the edge that the decoded instruction becomes valid. An optional scoreboard stalls issue on pending-write hazards.

## Interface
- `XLEN`, 32: instruction, PC and immediate width.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset); sampled on `clk` rising edge.
- `en`  in  1  stage enable; 0 freezes the stage.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `instr`  in  XLEN  instruction word.
- `pc_in`  in  XLEN  instruction address.
- `rs1`, `rs2`  out  5  register-file read addresses, combinational from `instr`.
- `rf_readEn`  out  1  register-file read enable; equals the accept condition.
- `out_valid`  out  1  decoded instruction held for execute.
- `out_ready`  in  1  execute consumes.
- `opcode`  out  7  registered `instr[6:0]`.
- `funct3`  out  3  registered `instr[14:12]`.
- `funct7`  out  7  registered `instr[31:25]`.
- `imm`  out  XLEN  registered sign-extended immediate.
- `rd`  out  5  registered destination.
- `rd_wen`  out  1  instruction writes `rd` (0 if `rd`==0).
- `pc_out`  out  XLEN  registered `pc_in`.
- `illegal`  out  1  unsupported opcode.
- `wb_valid`  in  1  writeback is writing the register file this cycle.
- `wb_rd`  in  5  writeback destination.

## Operation
- Accept condition: `reset`=1, `en`=1, `in_valid`=1, state is not HALT, (`out_valid`=0 or `out_ready`=1), `wb_valid`=0, and no hazard. `in_ready` is this condition without the `in_valid` term.
- `wb_valid` blocks accept. The register file ignores reads during writes.
- FSM states:
  - EMPTY → FULL on accept.
  - FULL → FULL on accept with `out_ready`.
  - FULL → EMPTY on `out_ready` without accept.
  - Any state → HALT when an illegal instruction is accepted. The `out_valid`/`illegal` output is still presented once.
  - HALT: `in_ready`=0 until reset. `out_valid` drops after the illegal word is consumed.
- Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011. All others set `illegal`=1, `rd_wen`=0, `imm`=0.
- Immediate formats, sign bit `instr[31]`:
  - I: LOAD, OP-IMM, JALR.
  - S: STORE.
  - B: BRANCH, bit0=0.
  - U: LUI, AUIPC, low 12 bits 0.
  - J: JAL, bit0=0.
- Source usage:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
  - `rd_wen` set for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP when `rd`≠0.
- `en`=0: no accept; outputs, state and scoreboard bits hold. Exception: writeback clears still apply.

## Timing
- Accept at edge T: the register file samples `rs1`/`rs2` at T. Decoded fields, `out_valid` and register-file data are all valid after T. Decode latency is 1 cycle.
- Throughput is 1 instruction/cycle when `out_ready`=1 and no stalls.
- Output registers change only on accept. They are held stable while `out_valid`=1 and `out_ready`=0.
- Reset (edge with `reset`=0): all registered outputs are 0, state is EMPTY, scoreboard is clear, `in_ready`=0. Reset mid-stall discards the held instruction; nothing is replayed.

## Configuration
- `DECODE_SCOREBOARD_EN` defined:
  - 31-bit busy vector for x1–x31; x0 is never busy.
  - Set `busy[rd]` on accept with `rd_wen`. Clear `busy[wb_rd]` on `wb_valid`.
  - If set and clear hit the same register in one cycle, set wins.
  - Hazard = (rs1 used and `busy[rs1]`) or (rs2 used and `busy[rs2]`) or (`rd_wen` and `busy[rd]`). The check uses the registered busy value with no bypass.
- `DECODE_SCOREBOARD_EN` undefined: no busy vector; hazard is constant 0. Downstream owns forwarding.

## Test plan
- Reset then ADDI x5,x0,-1 (0xFFF00293) with `out_ready`=1 → one cycle later `out_valid`=1, `opcode`=0x13, `rd`=5, `imm`=0xFFFFFFFF, `rd_wen`=1; `rf_readEn`=1 in the accept cycle with `rs1`=0.
- `out_ready`=0 for 3 cycles after SW x2,8(x1) (0x0020A423) → `in_ready`=0; `imm`=8, `rd_wen`=0 and `pc_out` stay stable.
- `wb_valid`=1 while `in_valid`=1 → `in_ready`=0 and `rf_readEn`=0; accept occurs the first cycle `wb_valid`=0.
- With `DECODE_SCOREBOARD_EN`: issue ADDI x5 then ADD x6,x5,x5 → ADD stalls until `wb_valid`=1 with `wb_rd`=5, then accepts on the next cycle.
- Instruction 0xFFFFFFFF → `illegal`=1, `rd_wen`=0, `imm`=0; later instructions are refused until `reset`=0 for one edge, after which normal accept resumes.
